// File: rtl/vxe_axi4slv_biu.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : vxe_axi4slv_biu                                               |
// | Purpose  : AXI4 slave bus interface unit. Turns single-beat AXI4 reads   |
// |            and writes into the BIU request/accept register interface.    |
// |            Read and write paths are independent and each path allows one |
// |            transaction in flight at a time.                              |
// | Ports    : S_AXI4_ACLK/ARESETn   clock / async reset (1 = reset)         |
// |            S_AXI4_AW*, W*, B*    AXI4 write address, data and response   |
// |            S_AXI4_AR*, R*        AXI4 read address and data              |
// |            biu_w*                BIU write request, accept and error     |
// |            biu_r*                BIU read request, data, accept, error   |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module vxe_axi4slv_biu #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int ID_WIDTH   = 8
) (
  input  logic                      S_AXI4_ACLK,
  input  logic                      S_AXI4_ARESETn,
  // AW channel
  input  logic [ID_WIDTH-1:0]       S_AXI4_AWID,
  input  logic [ADDR_WIDTH-1:0]     S_AXI4_AWADDR,
  input  logic [7:0]                S_AXI4_AWLEN,
  input  logic [2:0]                S_AXI4_AWSIZE,
  input  logic [1:0]                S_AXI4_AWBURST,
  input  logic                      S_AXI4_AWLOCK,
  input  logic [3:0]                S_AXI4_AWCACHE,
  input  logic [2:0]                S_AXI4_AWPROT,
  input  logic                      S_AXI4_AWVALID,
  output logic                      S_AXI4_AWREADY,
  // W channel
  input  logic [DATA_WIDTH-1:0]     S_AXI4_WDATA,
  input  logic [DATA_WIDTH/8-1:0]   S_AXI4_WSTRB,
  input  logic                      S_AXI4_WLAST,
  input  logic                      S_AXI4_WVALID,
  output logic                      S_AXI4_WREADY,
  // B channel
  output logic [ID_WIDTH-1:0]       S_AXI4_BID,
  output logic [1:0]                S_AXI4_BRESP,
  output logic                      S_AXI4_BVALID,
  input  logic                      S_AXI4_BREADY,
  // AR channel
  input  logic [ID_WIDTH-1:0]       S_AXI4_ARID,
  input  logic [ADDR_WIDTH-1:0]     S_AXI4_ARADDR,
  input  logic [7:0]                S_AXI4_ARLEN,
  input  logic [2:0]                S_AXI4_ARSIZE,
  input  logic [1:0]                S_AXI4_ARBURST,
  input  logic                      S_AXI4_ARLOCK,
  input  logic [3:0]                S_AXI4_ARCACHE,
  input  logic [2:0]                S_AXI4_ARPROT,
  input  logic                      S_AXI4_ARVALID,
  output logic                      S_AXI4_ARREADY,
  // R channel
  output logic [ID_WIDTH-1:0]       S_AXI4_RID,
  output logic [DATA_WIDTH-1:0]     S_AXI4_RDATA,
  output logic [1:0]                S_AXI4_RRESP,
  output logic                      S_AXI4_RLAST,
  output logic                      S_AXI4_RVALID,
  input  logic                      S_AXI4_RREADY,
  // BIU write path
  output logic [ADDR_WIDTH-1:0]     biu_waddr,
  output logic                      biu_wenable,
  output logic [DATA_WIDTH-1:0]     biu_wdata,
  output logic [DATA_WIDTH/8-1:0]   biu_wben,
  input  logic                      biu_waccept,
  input  logic                      biu_werror,
  // BIU read path
  output logic [ADDR_WIDTH-1:0]     biu_raddr,
  output logic                      biu_renable,
  input  logic [DATA_WIDTH-1:0]     biu_rdata,
  input  logic                      biu_raccept,
  input  logic                      biu_rerror
);

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  // Burst, size, cache, protection and lock attributes carry no meaning for a
  // single-beat register interface. Exclusive accesses complete as normal
  // accesses with OKAY, which AXI defines as exclusive failure.
  logic w_unused_ok;
  assign w_unused_ok = ^{S_AXI4_AWLEN, S_AXI4_AWSIZE, S_AXI4_AWBURST, S_AXI4_AWLOCK,
                         S_AXI4_AWCACHE, S_AXI4_AWPROT, S_AXI4_WLAST,
                         S_AXI4_ARLEN, S_AXI4_ARSIZE, S_AXI4_ARBURST, S_AXI4_ARLOCK,
                         S_AXI4_ARCACHE, S_AXI4_ARPROT};

  // --------------------------------------------------------------------------
  // Read path
  // --------------------------------------------------------------------------
  typedef enum logic [1:0] {
    R_IDLE = 2'd0,
    R_BIU  = 2'd1,
    R_RESP = 2'd2
  } rstate_e;

  rstate_e                 rstate_q, rstate_d;
  logic [ID_WIDTH-1:0]     rid_q, rid_d;
  logic [ADDR_WIDTH-1:0]   raddr_q, raddr_d;
  logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;
  logic [1:0]              rresp_q, rresp_d;

  always_comb begin
    rstate_d = rstate_q;
    rid_d    = rid_q;
    raddr_d  = raddr_q;
    rdata_d  = rdata_q;
    rresp_d  = rresp_q;
    case (rstate_q)
      R_IDLE: begin
        if (S_AXI4_ARVALID) begin
          rid_d    = S_AXI4_ARID;
          raddr_d  = S_AXI4_ARADDR;
          rstate_d = R_BIU;
        end
      end
      R_BIU: begin
        if (biu_raccept) begin
          rdata_d  = biu_rdata;
          rresp_d  = biu_rerror ? RESP_SLVERR : RESP_OKAY;
          rstate_d = R_RESP;
        end
      end
      R_RESP: begin
        if (S_AXI4_RREADY) rstate_d = R_IDLE;
      end
      default: rstate_d = R_IDLE;
    endcase
  end

  always_ff @(posedge S_AXI4_ACLK or posedge S_AXI4_ARESETn) begin
    if (S_AXI4_ARESETn) begin
      rstate_q <= R_IDLE;
      rid_q    <= '0;
      raddr_q  <= '0;
      rdata_q  <= '0;
      rresp_q  <= RESP_OKAY;
    end else begin
      rstate_q <= rstate_d;
      rid_q    <= rid_d;
      raddr_q  <= raddr_d;
      rdata_q  <= rdata_d;
      rresp_q  <= rresp_d;
    end
  end

  // READY is masked by reset so nothing is handshaken while reset is held.
  assign S_AXI4_ARREADY = (rstate_q == R_IDLE) && !S_AXI4_ARESETn;
  assign S_AXI4_RVALID  = (rstate_q == R_RESP);
  assign S_AXI4_RLAST   = (rstate_q == R_RESP);
  assign S_AXI4_RID     = rid_q;
  assign S_AXI4_RDATA   = rdata_q;
  assign S_AXI4_RRESP   = rresp_q;
  assign biu_renable    = (rstate_q == R_BIU);
  assign biu_raddr      = raddr_q;

  // --------------------------------------------------------------------------
  // Write path
  // --------------------------------------------------------------------------
  typedef enum logic [1:0] {
    W_IDLE = 2'd0,
    W_BIU  = 2'd1,
    W_RESP = 2'd2
  } wstate_e;

  wstate_e                 wstate_q, wstate_d;
  logic                    aw_held_q, aw_held_d;
  logic                    w_held_q, w_held_d;
  logic [ID_WIDTH-1:0]     bid_q, bid_d;
  logic [ADDR_WIDTH-1:0]   waddr_q, waddr_d;
  logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
  logic [DATA_WIDTH/8-1:0] wstrb_q, wstrb_d;
  logic [1:0]              bresp_q, bresp_d;

  always_comb begin
    wstate_d  = wstate_q;
    aw_held_d = aw_held_q;
    w_held_d  = w_held_q;
    bid_d     = bid_q;
    waddr_d   = waddr_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    bresp_d   = bresp_q;
    case (wstate_q)
      W_IDLE: begin
        // Address and data are collected independently; the BIU access starts
        // once both are held, whichever arrived last.
        if (S_AXI4_AWVALID && !aw_held_q) begin
          bid_d     = S_AXI4_AWID;
          waddr_d   = S_AXI4_AWADDR;
          aw_held_d = 1'b1;
        end
        if (S_AXI4_WVALID && !w_held_q) begin
          wdata_d  = S_AXI4_WDATA;
          wstrb_d  = S_AXI4_WSTRB;
          w_held_d = 1'b1;
        end
        if (aw_held_d && w_held_d) wstate_d = W_BIU;
      end
      W_BIU: begin
        if (biu_waccept) begin
          bresp_d  = biu_werror ? RESP_SLVERR : RESP_OKAY;
          wstate_d = W_RESP;
        end
      end
      W_RESP: begin
        if (S_AXI4_BREADY) begin
          aw_held_d = 1'b0;
          w_held_d  = 1'b0;
          wstate_d  = W_IDLE;
        end
      end
      default: wstate_d = W_IDLE;
    endcase
  end

  always_ff @(posedge S_AXI4_ACLK or posedge S_AXI4_ARESETn) begin
    if (S_AXI4_ARESETn) begin
      wstate_q  <= W_IDLE;
      aw_held_q <= 1'b0;
      w_held_q  <= 1'b0;
      bid_q     <= '0;
      waddr_q   <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      bresp_q   <= RESP_OKAY;
    end else begin
      wstate_q  <= wstate_d;
      aw_held_q <= aw_held_d;
      w_held_q  <= w_held_d;
      bid_q     <= bid_d;
      waddr_q   <= waddr_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
      bresp_q   <= bresp_d;
    end
  end

  assign S_AXI4_AWREADY = (wstate_q == W_IDLE) && !aw_held_q && !S_AXI4_ARESETn;
  assign S_AXI4_WREADY  = (wstate_q == W_IDLE) && !w_held_q && !S_AXI4_ARESETn;
  assign S_AXI4_BVALID  = (wstate_q == W_RESP);
  assign S_AXI4_BID     = bid_q;
  assign S_AXI4_BRESP   = bresp_q;
  assign biu_wenable    = (wstate_q == W_BIU);
  assign biu_waddr      = waddr_q;
  assign biu_wdata      = wdata_q;
  assign biu_wben       = wstrb_q;

endmodule
`default_nettype wire

// File: tb/tb_vxe_axi4slv_biu.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_vxe_axi4slv_biu                                            |
// | Purpose  : Directed self-checking bench for vxe_axi4slv_biu.             |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module tb_vxe_axi4slv_biu;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  awid = '0;
  logic [31:0] awaddr = '0;
  logic        awvalid = 1'b0;
  logic        awready;
  logic [31:0] wdata = '0;
  logic [3:0]  wstrb = '0;
  logic        wvalid = 1'b0;
  logic        wready;
  logic [7:0]  bid;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready = 1'b0;
  logic [7:0]  arid = '0;
  logic [31:0] araddr = '0;
  logic        arlock = 1'b0;
  logic        arvalid = 1'b0;
  logic        arready;
  logic [7:0]  rid;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rlast;
  logic        rvalid;
  logic        rready = 1'b0;
  logic [31:0] biu_waddr;
  logic        biu_wenable;
  logic [31:0] biu_wdata;
  logic [3:0]  biu_wben;
  logic        biu_waccept = 1'b0;
  logic        biu_werror = 1'b0;
  logic [31:0] biu_raddr;
  logic        biu_renable;
  logic [31:0] biu_rdata = '0;
  logic        biu_raccept = 1'b0;
  logic        biu_rerror = 1'b0;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  vxe_axi4slv_biu dut (
    .S_AXI4_ACLK(clk), .S_AXI4_ARESETn(rst),
    .S_AXI4_AWID(awid), .S_AXI4_AWADDR(awaddr), .S_AXI4_AWLEN(8'd0),
    .S_AXI4_AWSIZE(3'd2), .S_AXI4_AWBURST(2'b01), .S_AXI4_AWLOCK(1'b0),
    .S_AXI4_AWCACHE(4'd0), .S_AXI4_AWPROT(3'd0), .S_AXI4_AWVALID(awvalid),
    .S_AXI4_AWREADY(awready),
    .S_AXI4_WDATA(wdata), .S_AXI4_WSTRB(wstrb), .S_AXI4_WLAST(1'b1),
    .S_AXI4_WVALID(wvalid), .S_AXI4_WREADY(wready),
    .S_AXI4_BID(bid), .S_AXI4_BRESP(bresp), .S_AXI4_BVALID(bvalid), .S_AXI4_BREADY(bready),
    .S_AXI4_ARID(arid), .S_AXI4_ARADDR(araddr), .S_AXI4_ARLEN(8'd0),
    .S_AXI4_ARSIZE(3'd2), .S_AXI4_ARBURST(2'b01), .S_AXI4_ARLOCK(arlock),
    .S_AXI4_ARCACHE(4'd0), .S_AXI4_ARPROT(3'd0), .S_AXI4_ARVALID(arvalid),
    .S_AXI4_ARREADY(arready),
    .S_AXI4_RID(rid), .S_AXI4_RDATA(rdata), .S_AXI4_RRESP(rresp), .S_AXI4_RLAST(rlast),
    .S_AXI4_RVALID(rvalid), .S_AXI4_RREADY(rready),
    .biu_waddr(biu_waddr), .biu_wenable(biu_wenable), .biu_wdata(biu_wdata),
    .biu_wben(biu_wben), .biu_waccept(biu_waccept), .biu_werror(biu_werror),
    .biu_raddr(biu_raddr), .biu_renable(biu_renable), .biu_rdata(biu_rdata),
    .biu_raccept(biu_raccept), .biu_rerror(biu_rerror)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    step();
    n_checks++;
    if ({arready, awready, wready, rvalid, bvalid, biu_renable, biu_wenable} !== 7'b0) begin
      n_errors++;
      $display("FAIL reset_ctrl: got %b expected 0000000",
               {arready, awready, wready, rvalid, bvalid, biu_renable, biu_wenable});
    end
    n_checks++;
    if ({rdata, rid, bid, rresp, bresp, rlast, biu_raddr, biu_waddr, biu_wdata, biu_wben} !== '0) begin
      n_errors++;
      $display("FAIL reset_regs: rdata=%h rid=%h bid=%h raddr=%h waddr=%h wdata=%h wben=%h expected all 0",
               rdata, rid, bid, biu_raddr, biu_waddr, biu_wdata, biu_wben);
    end
    rst = 1'b0;
    #1;
    n_checks++;
    if ({arready, awready, wready} !== 3'b111) begin
      n_errors++;
      $display("FAIL reset_release_ready: got %b expected 111", {arready, awready, wready});
    end
    step();
  endtask

  // Single read; acc_dly/rr_dly are cycles the BIU accept / RREADY are held low.
  task automatic run_read(input string nm, input logic [31:0] addr, input logic [7:0] id,
                          input logic [31:0] data, input logic err, input logic lock,
                          input int acc_dly, input int rr_dly);
    logic [1:0] exp_resp;
    exp_resp    = err ? 2'b10 : 2'b00;
    arvalid     = 1'b1;
    araddr      = addr;
    arid        = id;
    arlock      = lock;
    biu_rdata   = data;
    biu_rerror  = err;
    biu_raccept = (acc_dly == 0);
    rready      = (rr_dly == 0);
    n_checks++;
    if (arready !== 1'b1) begin
      n_errors++;
      $display("FAIL %s arready_idle: got %b expected 1", nm, arready);
    end
    step();
    arvalid = 1'b0;
    n_checks++;
    if ({biu_renable, biu_raddr, rvalid, arready} !== {1'b1, addr, 1'b0, 1'b0}) begin
      n_errors++;
      $display("FAIL %s biu_req: renable=%b raddr=%h rvalid=%b arready=%b expected 1 %h 0 0",
               nm, biu_renable, biu_raddr, rvalid, arready, addr);
    end
    for (int i = 0; i < acc_dly; i++) begin
      step();
      n_checks++;
      if ({biu_renable, rvalid} !== 2'b10) begin
        n_errors++;
        $display("FAIL %s accept_stall: renable=%b rvalid=%b expected 1 0", nm, biu_renable, rvalid);
      end
    end
    biu_raccept = 1'b1;
    step();
    biu_raccept = 1'b0;
    biu_rdata   = ~data;
    biu_rerror  = ~err;
    n_checks++;
    if ({rvalid, rlast, rid, rresp, rdata, biu_renable} !== {1'b1, 1'b1, id, exp_resp, data, 1'b0}) begin
      n_errors++;
      $display("FAIL %s r_beat: rvalid=%b rlast=%b rid=%h rresp=%b rdata=%h renable=%b expected 1 1 %h %b %h 0",
               nm, rvalid, rlast, rid, rresp, rdata, biu_renable, id, exp_resp, data);
    end
    for (int i = 0; i < rr_dly; i++) begin
      step();
      n_checks++;
      if ({rvalid, rresp, rdata, arready} !== {1'b1, exp_resp, data, 1'b0}) begin
        n_errors++;
        $display("FAIL %s r_hold: rvalid=%b rresp=%b rdata=%h arready=%b expected 1 %b %h 0",
                 nm, rvalid, rresp, rdata, arready, exp_resp, data);
      end
    end
    rready = 1'b1;
    step();
    rready = 1'b0;
    arlock = 1'b0;
    n_checks++;
    if ({rvalid, arready} !== 2'b01) begin
      n_errors++;
      $display("FAIL %s r_done: rvalid=%b arready=%b expected 0 1", nm, rvalid, arready);
    end
  endtask

  // Single write; w_dly delays W after AW, acc_dly/br_dly hold accept / BREADY low.
  task automatic run_write(input string nm, input logic [31:0] addr, input logic [7:0] id,
                           input logic [31:0] data, input logic [3:0] strb, input logic err,
                           input int w_dly, input int acc_dly, input int br_dly);
    logic [1:0] exp_resp;
    exp_resp    = err ? 2'b10 : 2'b00;
    awvalid     = 1'b1;
    awaddr      = addr;
    awid        = id;
    wvalid      = (w_dly == 0);
    wdata       = data;
    wstrb       = strb;
    biu_werror  = err;
    biu_waccept = (acc_dly == 0);
    bready      = (br_dly == 0);
    n_checks++;
    if ({awready, wready} !== 2'b11) begin
      n_errors++;
      $display("FAIL %s ready_idle: got %b expected 11", nm, {awready, wready});
    end
    step();
    awvalid = 1'b0;
    wvalid  = 1'b0;
    if (w_dly > 0) begin
      for (int i = 0; i < w_dly - 1; i++) begin
        n_checks++;
        if ({biu_wenable, awready, wready} !== 3'b001) begin
          n_errors++;
          $display("FAIL %s wait_data: wenable=%b awready=%b wready=%b expected 0 0 1",
                   nm, biu_wenable, awready, wready);
        end
        step();
      end
      wvalid = 1'b1;
      step();
      wvalid = 1'b0;
    end
    n_checks++;
    if ({biu_wenable, biu_waddr, biu_wdata, biu_wben, awready, wready, bvalid} !==
        {1'b1, addr, data, strb, 3'b000}) begin
      n_errors++;
      $display("FAIL %s biu_req: wenable=%b waddr=%h wdata=%h wben=%h aw/w/b=%b expected 1 %h %h %h 000",
               nm, biu_wenable, biu_waddr, biu_wdata, biu_wben, {awready, wready, bvalid},
               addr, data, strb);
    end
    for (int i = 0; i < acc_dly; i++) begin
      step();
      n_checks++;
      if ({biu_wenable, bvalid} !== 2'b10) begin
        n_errors++;
        $display("FAIL %s accept_stall: wenable=%b bvalid=%b expected 1 0", nm, biu_wenable, bvalid);
      end
    end
    biu_waccept = 1'b1;
    step();
    biu_waccept = 1'b0;
    biu_werror  = ~err;
    n_checks++;
    if ({bvalid, bid, bresp, biu_wenable} !== {1'b1, id, exp_resp, 1'b0}) begin
      n_errors++;
      $display("FAIL %s b_resp: bvalid=%b bid=%h bresp=%b wenable=%b expected 1 %h %b 0",
               nm, bvalid, bid, bresp, biu_wenable, id, exp_resp);
    end
    for (int i = 0; i < br_dly; i++) begin
      step();
      n_checks++;
      if ({bvalid, bid, bresp, awready, wready} !== {1'b1, id, exp_resp, 2'b00}) begin
        n_errors++;
        $display("FAIL %s b_hold: bvalid=%b bid=%h bresp=%b aw/w=%b expected 1 %h %b 00",
                 nm, bvalid, bid, bresp, {awready, wready}, id, exp_resp);
      end
    end
    bready = 1'b1;
    step();
    bready = 1'b0;
    n_checks++;
    if ({bvalid, awready, wready} !== 3'b011) begin
      n_errors++;
      $display("FAIL %s b_done: bvalid=%b aw/w=%b expected 0 11", nm, bvalid, {awready, wready});
    end
  endtask

  task automatic test_read();
    run_read("rd_basic", 32'h0000_000C, 8'h01, 32'hFEFE_FAFA, 1'b0, 1'b0, 0, 0);
    run_read("rd_rready_dly", 32'h0000_000C, 8'h01, 32'hFEFE_FAFA, 1'b0, 1'b0, 0, 2);
    run_read("rd_accept_dly", 32'h0000_000C, 8'h01, 32'hFEFE_FAFA, 1'b0, 1'b0, 2, 0);
  endtask

  task automatic test_read_lock_error();
    run_read("rd_lock_err", 32'h0000_0080, 8'h05, 32'hFAFA_DADA, 1'b1, 1'b1, 0, 0);
    run_read("rd_lock_ok", 32'h0000_0080, 8'h06, 32'hFAFA_DADA, 1'b0, 1'b1, 0, 0);
  endtask

  task automatic test_write();
    run_write("wr_basic", 32'h0000_000C, 8'h02, 32'hF1F2_F3F4, 4'hF, 1'b0, 0, 0, 0);
    run_write("wr_bready_dly", 32'h0000_0010, 8'h03, 32'hF5F6_F7F8, 4'h3, 1'b0, 0, 0, 2);
    run_write("wr_accept_dly_err", 32'h0000_0020, 8'h04, 32'hF9F8_F7F6, 4'hC, 1'b1, 0, 2, 0);
    run_write("wr_data_late", 32'h0000_0030, 8'h07, 32'hF7F7_F7F7, 4'hF, 1'b0, 3, 0, 0);
  endtask

  task automatic test_concurrent();
    fork
      run_read("cc_rd", 32'h0000_0044, 8'hA5, 32'h1234_5678, 1'b0, 1'b0, 1, 1);
      run_write("cc_wr", 32'h0000_0048, 8'h5A, 32'h8765_4321, 4'h5, 1'b0, 0, 1, 0);
    join
  endtask

  task automatic test_reset_mid();
    awvalid     = 1'b1;
    awaddr      = 32'h0000_0040;
    awid        = 8'h09;
    wvalid      = 1'b1;
    wdata       = 32'hDEAD_BEEF;
    wstrb       = 4'hF;
    biu_waccept = 1'b0;
    bready      = 1'b1;
    step();
    awvalid = 1'b0;
    wvalid  = 1'b0;
    n_checks++;
    if (biu_wenable !== 1'b1) begin
      n_errors++;
      $display("FAIL rst_mid_pre: wenable=%b expected 1", biu_wenable);
    end
    rst = 1'b1;
    #1;
    n_checks++;
    if ({biu_wenable, bvalid, awready, wready, arready, biu_waddr, biu_wdata} !== '0) begin
      n_errors++;
      $display("FAIL rst_mid_abort: wenable=%b bvalid=%b rdy=%b waddr=%h wdata=%h expected all 0",
               biu_wenable, bvalid, {awready, wready, arready}, biu_waddr, biu_wdata);
    end
    step();
    rst = 1'b0;
    biu_waccept = 1'b1;
    step();
    n_checks++;
    if ({bvalid, biu_wenable, awready, wready} !== 4'b0011) begin
      n_errors++;
      $display("FAIL rst_mid_after: bvalid=%b wenable=%b aw/w=%b expected 0 0 11",
               bvalid, biu_wenable, {awready, wready});
    end
    biu_waccept = 1'b0;
    bready      = 1'b0;
  endtask

  initial begin
    test_reset();
    test_read();
    test_read_lock_error();
    test_write();
    test_concurrent();
    test_reset_mid();
    step();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
